// File: rtl/pixel_sequencer.sv
// Frame sequencer for the pixel array: erase, exposure, ramp conversion, row readout.
// Outputs are registered from the next-state values, so they change on the same edge as the state.
`timescale 1ns/1ps
module pixel_sequencer #(
    parameter int ROWS           = 4,
    parameter int RAMP_BITS      = 8,
    parameter int EXP_BITS       = 8,
    parameter int ERASE_CYCLES   = 5,
    parameter int READ_CYCLES    = 2,
    parameter int EXPOSE_CLK_DIV = 2,
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [EXP_BITS-1:0]  expose_time,
    output logic                 p_erase,
    output logic                 p_expose,
    output logic                 p_expose_clk,
    output logic [RAMP_BITS-1:0] p_dRamp,
    output logic [ROWS-1:0]      p_row_select,
    output logic                 row_valid,
    output logic [RIW-1:0]       row_index,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int EW   = $clog2(ERASE_CYCLES + 1);
    localparam int RW   = $clog2(READ_CYCLES + 1);
    localparam int DW   = $clog2(EXPOSE_CLK_DIV + 1);
    localparam int CW_A = (RAMP_BITS > EXP_BITS) ? RAMP_BITS : EXP_BITS;
    localparam int CW_B = (EW > RW) ? EW : RW;
    localparam int CW   = (CW_A > CW_B) ? CW_A : CW_B;

    localparam logic [CW-1:0]  ERASE_LAST = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0]  READ_LAST  = CW'(READ_CYCLES - 1);
    localparam logic [CW-1:0]  RAMP_LAST  = CW'((1 << RAMP_BITS) - 1);
    localparam logic [RIW-1:0] ROW_LAST   = RIW'(ROWS - 1);
    localparam logic [DW-1:0]  DIV_LAST   = DW'(EXPOSE_CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READOUT, S_DONE
    } state_t;

    state_t               r_state, w_nstate;
    logic [CW-1:0]        r_cnt, w_ncnt, w_cnt_inc, w_exp_last;
    logic [RIW-1:0]       r_row, w_nrow;
    logic [EXP_BITS-1:0]  r_exp, w_nexp, w_latch_e;
    logic [DW-1:0]        r_div, w_ndiv;

    logic                 w_erase, w_expose, w_expclk, w_rowvalid, w_busy, w_done;
    logic [RAMP_BITS-1:0] w_ramp;
    logic [ROWS-1:0]      w_rowsel;
    logic [RIW-1:0]       w_rowidx;

    assign w_latch_e  = (expose_time == '0) ? EXP_BITS'(1) : expose_time;
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_exp_last = CW'(r_exp) - CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_exp        <= '0;
            r_div        <= '0;
            p_erase      <= 1'b0;
            p_expose     <= 1'b0;
            p_expose_clk <= 1'b0;
            p_dRamp      <= '0;
            p_row_select <= '0;
            row_valid    <= 1'b0;
            row_index    <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_state      <= w_nstate;
            r_cnt        <= w_ncnt;
            r_row        <= w_nrow;
            r_exp        <= w_nexp;
            r_div        <= w_ndiv;
            p_erase      <= w_erase;
            p_expose     <= w_expose;
            p_expose_clk <= w_expclk;
            p_dRamp      <= w_ramp;
            p_row_select <= w_rowsel;
            row_valid    <= w_rowvalid;
            row_index    <= w_rowidx;
            busy         <= w_busy;
            frame_done   <= w_done;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = w_cnt_inc;
        w_nrow   = r_row;
        w_nexp   = r_exp;
        w_ndiv   = (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
        case (r_state)
            S_IDLE: begin
                w_ncnt = '0;
                w_nrow = '0;
                w_ndiv = '0;
                if (start || continuous) begin
                    w_nstate = S_ERASE;
                    w_nexp   = w_latch_e;
                end
            end
            S_ERASE: begin
                // Divider restarts so the pulse train fires on exposure cycle 0.
                w_ndiv = '0;
                if (r_cnt == ERASE_LAST) begin
                    w_nstate = S_EXPOSE;
                    w_ncnt   = '0;
                end
            end
            S_EXPOSE: begin
                if (r_cnt == w_exp_last) begin
                    w_nstate = S_CONVERT;
                    w_ncnt   = '0;
                end
            end
            S_CONVERT: begin
                w_nrow = '0;
                if (r_cnt == RAMP_LAST) begin
                    w_nstate = S_READOUT;
                    w_ncnt   = '0;
                end
            end
            S_READOUT: begin
                if (r_cnt == READ_LAST) begin
                    w_ncnt = '0;
                    if (r_row == ROW_LAST) w_nstate = S_DONE;
                    else                   w_nrow   = r_row + RIW'(1);
                end
            end
            S_DONE: begin
                w_ncnt = '0;
                w_nrow = '0;
                if (continuous) begin
                    w_nstate = S_ERASE;
                    w_nexp   = w_latch_e;
                end else begin
                    w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_erase    = (w_nstate == S_ERASE);
        w_expose   = (w_nstate == S_EXPOSE);
        w_expclk   = (w_nstate == S_EXPOSE) && (w_ndiv == '0);
        w_ramp     = (w_nstate == S_CONVERT) ? w_ncnt[RAMP_BITS-1:0] : '0;
        w_busy     = (w_nstate != S_IDLE);
        w_done     = (w_nstate == S_DONE);
        w_rowsel   = '0;
        w_rowvalid = 1'b0;
        w_rowidx   = '0;
        if (w_nstate == S_READOUT) begin
            w_rowsel   = ROWS'(1) << w_nrow;
            w_rowvalid = (w_ncnt == READ_LAST);
            w_rowidx   = w_nrow;
        end
    end
endmodule

// File: tb/tb_pixel_sequencer.sv
// Bench for pixel_sequencer: directed frames with per-frame expectations queued at stimulus time.
`timescale 1ns/1ps
module tb_pixel_sequencer;
  localparam int W = 33;  // {len[15:0], e[7:0], pulses[7:0], follow}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, continuous, start_b, cont_b;
  logic [7:0] expose_time, expose_time_b;

  logic       a_p_erase, a_p_expose, a_p_expose_clk, a_row_valid, a_busy, a_frame_done;
  logic [7:0] a_p_dRamp;
  logic [3:0] a_p_row_select;
  logic [1:0] a_row_index;

  logic       b_p_erase, b_p_expose, b_p_expose_clk, b_row_valid, b_busy, b_frame_done;
  logic [3:0] b_p_dRamp;
  logic [7:0] b_p_row_select;
  logic [2:0] b_row_index;

  pixel_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_time(expose_time), .p_erase(a_p_erase), .p_expose(a_p_expose),
    .p_expose_clk(a_p_expose_clk), .p_dRamp(a_p_dRamp), .p_row_select(a_p_row_select),
    .row_valid(a_row_valid), .row_index(a_row_index), .busy(a_busy), .frame_done(a_frame_done)
  );

  pixel_sequencer #(.ROWS(8), .RAMP_BITS(4), .READ_CYCLES(1), .EXPOSE_CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .continuous(cont_b),
    .expose_time(expose_time_b), .p_erase(b_p_erase), .p_expose(b_p_expose),
    .p_expose_clk(b_p_expose_clk), .p_dRamp(b_p_dRamp), .p_row_select(b_p_row_select),
    .row_valid(b_row_valid), .row_index(b_row_index), .busy(b_busy), .frame_done(b_frame_done)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_b_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rec(input int len, input int e, input int p, input logic f);
    return {len[15:0], e[7:0], p[7:0], f};
  endfunction

  // ---------------- monitor for dut_a ----------------
  int   a_len, a_er, a_ex, a_pc, a_cv, a_rs, a_rv, a_run;
  logic a_ramp_bad, a_row_bad, a_excl_bad, a_pend, a_follow;
  logic [W-1:0] a_rec;

  task automatic clear_a();
    a_len = 0; a_er = 0; a_ex = 0; a_pc = 0; a_cv = 0; a_rs = 0; a_rv = 0; a_run = 0;
    a_ramp_bad = 0; a_row_bad = 0; a_excl_bad = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      clear_a();
      a_pend = 0;
    end else begin
      if (a_pend) begin
        chk("a_next_erase", int'(a_p_erase), int'(a_follow));
        chk("a_next_busy", int'(a_busy), int'(a_follow));
        a_pend = 0;
      end
      if (a_busy) a_len++;
      if (a_p_erase) a_er++;
      if (a_p_expose) begin
        a_ex++;
        if (a_p_expose_clk) a_pc++;
      end else if (a_p_expose_clk) a_excl_bad = 1;
      if (int'(a_p_erase) + int'(a_p_expose) + int'(|a_p_row_select) > 1) a_excl_bad = 1;
      if (a_busy && !a_p_erase && !a_p_expose && a_p_row_select == 0 && !a_frame_done) begin
        if (int'(a_p_dRamp) != a_cv) a_ramp_bad = 1;
        a_cv++;
      end else if (a_p_dRamp != 0) a_ramp_bad = 1;
      if (a_p_row_select != 0) begin
        a_rs++;
        a_run++;
        if (a_p_row_select != (4'b0001 << a_row_index)) a_row_bad = 1;
      end
      if (a_row_valid) begin
        if (a_p_row_select == 0 || int'(a_row_index) != a_rv || a_run != 2) a_row_bad = 1;
        a_rv++;
        a_run = 0;
      end
      if (a_frame_done) begin
        if (exp_q.size() == 0) begin
          chk("a_unexpected_frame_done", 1, 0);
        end else begin
          a_rec = exp_q.pop_front();
          chk("a_frame_len", a_len, int'(a_rec[32:17]));
          chk("a_erase_cycles", a_er, 5);
          chk("a_expose_cycles", a_ex, int'(a_rec[16:9]));
          chk("a_expose_clk_pulses", a_pc, int'(a_rec[8:1]));
          chk("a_convert_cycles", a_cv, 256);
          chk("a_ramp_sequence_bad", int'(a_ramp_bad), 0);
          chk("a_rows_valid", a_rv, 4);
          chk("a_row_select_cycles", a_rs, 8);
          chk("a_row_order_bad", int'(a_row_bad), 0);
          chk("a_control_overlap", int'(a_excl_bad), 0);
          a_follow = a_rec[0];
          a_pend = 1;
        end
        clear_a();
      end
    end
  end

  // ---------------- monitor for dut_b ----------------
  int   b_len, b_ex, b_pc, b_cv, b_rs, b_rv;
  logic b_ramp_bad, b_row_bad, b_excl_bad;
  logic [15:0] b_rec;

  task automatic clear_b();
    b_len = 0; b_ex = 0; b_pc = 0; b_cv = 0; b_rs = 0; b_rv = 0;
    b_ramp_bad = 0; b_row_bad = 0; b_excl_bad = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      clear_b();
    end else begin
      if (b_busy) b_len++;
      if (b_p_expose) begin
        b_ex++;
        if (b_p_expose_clk) b_pc++;
      end
      if (int'(b_p_erase) + int'(b_p_expose) + int'(|b_p_row_select) > 1) b_excl_bad = 1;
      if (b_busy && !b_p_erase && !b_p_expose && b_p_row_select == 0 && !b_frame_done) begin
        if (int'(b_p_dRamp) != b_cv) b_ramp_bad = 1;
        b_cv++;
      end else if (b_p_dRamp != 0) b_ramp_bad = 1;
      if (b_p_row_select != 0) begin
        b_rs++;
        if (b_p_row_select != (8'b0000_0001 << b_row_index) || !b_row_valid) b_row_bad = 1;
      end
      if (b_row_valid) begin
        if (int'(b_row_index) != b_rv) b_row_bad = 1;
        b_rv++;
      end
      if (b_frame_done) begin
        if (exp_b_q.size() == 0) begin
          chk("b_unexpected_frame_done", 1, 0);
        end else begin
          b_rec = exp_b_q.pop_front();
          chk("b_frame_len", b_len, int'(b_rec));
          chk("b_expose_cycles", b_ex, 10);
          chk("b_expose_clk_high", b_pc, 10);
          chk("b_convert_cycles", b_cv, 16);
          chk("b_ramp_sequence_bad", int'(b_ramp_bad), 0);
          chk("b_rows_valid", b_rv, 8);
          chk("b_row_select_cycles", b_rs, 8);
          chk("b_row_order_bad", int'(b_row_bad), 0);
          chk("b_control_overlap", int'(b_excl_bad), 0);
        end
        clear_b();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done_a(input int n, input int budget, input string name);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      step();
      cyc++;
      if (a_frame_done) seen++;
    end
    if (seen < n) chk(name, seen, n);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_erase"}, int'(a_p_erase), 0);
    chk({tag, "_expose"}, int'(a_p_expose), 0);
    chk({tag, "_expose_clk"}, int'(a_p_expose_clk), 0);
    chk({tag, "_dramp"}, int'(a_p_dRamp), 0);
    chk({tag, "_row_select"}, int'(a_p_row_select), 0);
    chk({tag, "_row_valid"}, int'(a_row_valid), 0);
    chk({tag, "_busy"}, int'(a_busy), 0);
    chk({tag, "_frame_done"}, int'(a_frame_done), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int extra;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; expose_time = 8'd10;
    start_b = 1'b0; cont_b = 1'b0; expose_time_b = 8'd10;
    step(2);
    check_all_zero("reset");
    chk("reset_b_busy", int'(b_busy), 0);
    reset = 1'b1;
    step(2);

    // Default single-shot frame.
    exp_q.push_back(rec(280, 10, 5, 1'b0));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_latency_erase", int'(a_p_erase), 1);
    chk("start_latency_busy", int'(a_busy), 1);
    wait_done_a(1, 400, "timeout_single");
    step(5);

    // Zero exposure is treated as one cycle.
    expose_time = 8'd0;
    exp_q.push_back(rec(271, 1, 1, 1'b0));
    pulse_start();
    wait_done_a(1, 400, "timeout_zero_exp");
    step(5);

    // Continuous: frame 1 keeps E=10, later frames pick up E=3.
    expose_time = 8'd10;
    exp_q.push_back(rec(280, 10, 5, 1'b1));
    exp_q.push_back(rec(273, 3, 2, 1'b1));
    exp_q.push_back(rec(273, 3, 2, 1'b0));
    continuous = 1'b1;
    step();
    expose_time = 8'd3;
    wait_done_a(2, 700, "timeout_cont_12");
    step(20);
    continuous = 1'b0;
    wait_done_a(1, 400, "timeout_cont_3");
    step(5);

    // Reset in the middle of the ramp.
    expose_time = 8'd10;
    pulse_start();
    cyc = 0;
    while (a_p_dRamp != 8'd100 && cyc < 400) begin
      step();
      cyc++;
    end
    chk("ramp_reached_100", int'(a_p_dRamp), 100);
    reset = 1'b0;
    step();
    check_all_zero("midreset");
    reset = 1'b1;
    step(3);
    exp_q.push_back(rec(280, 10, 5, 1'b0));
    pulse_start();
    wait_done_a(1, 400, "timeout_after_reset");
    step(5);

    // Start pulse while busy is ignored.
    exp_q.push_back(rec(280, 10, 5, 1'b0));
    pulse_start();
    cyc = 0;
    while (!a_p_expose && cyc < 50) begin
      step();
      cyc++;
    end
    chk("reached_expose", int'(a_p_expose), 1);
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done_a(1, 400, "timeout_busy_start");
    extra = 0;
    repeat (300) begin
      step();
      if (a_frame_done) extra++;
    end
    chk("busy_start_extra_frames", extra, 0);
    chk("busy_start_idle", int'(a_busy), 0);

    // Parameter sweep instance: 5 + 10 + 16 + 8 + 1.
    exp_b_q.push_back(16'd40);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cyc = 0;
    while (!b_frame_done && cyc < 100) begin
      step();
      cyc++;
    end
    chk("b_frame_seen", int'(b_frame_done), 1);
    step(5);

    chk("a_queue_drained", exp_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_sequencer.md
# pixel_sequencer

Parametrised successor to the pixel-array state controller. Sequences one image frame through erase, exposure, ramp conversion and row readout, and drives the pixel array's control lines. Supports a configurable row count, ramp width, per-frame runtime exposure length, single-shot or continuous capture, and a readout strobe for the downstream row buffer. Sits between the top-level capture control and the pixel array.

## Interface
- ROWS, 4: pixel array height; number of row-select lines (≥1)
- RAMP_BITS, 8: ramp DAC code width
- EXP_BITS, 8: width of the exposure-length input
- ERASE_CYCLES, 5: cycles `p_erase` is held high (≥1)
- READ_CYCLES, 2: cycles each row stays selected during readout (≥1)
- EXPOSE_CLK_DIV, 2: period, in clk cycles, of the `p_expose_clk` pulse train (≥1)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-shot frame request; sampled only in IDLE
- continuous  in  1  when high, frames repeat back-to-back
- expose_time  in  EXP_BITS  exposure length in cycles; latched at frame start; 0 is treated as 1
- p_erase  out  1  pixel erase
- p_expose  out  1  pixel exposure enable
- p_expose_clk  out  1  exposure pulse train
- p_dRamp  out  RAMP_BITS  ramp DAC code
- p_row_select  out  ROWS  one-hot row select
- row_valid  out  1  selected row's data is stable (last cycle of each row)
- row_index  out  max(1,$clog2(ROWS))  index of the selected row
- busy  out  1  frame in progress (any state other than IDLE)
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → READOUT → DONE → (ERASE if `continuous` else IDLE).
- All outputs are registered and are a function of state and counters only.
- IDLE:
  - All outputs 0.
  - `start|continuous` high → ERASE on the next edge.
  - `expose_time` is latched on the same edge as E = max(expose_time,1).
- ERASE: `p_erase`=1 for exactly ERASE_CYCLES cycles.
- EXPOSE:
  - `p_expose`=1 for exactly E cycles.
  - `p_expose_clk`=1 on exposure cycles 0, DIV, 2·DIV, …; with DIV=1 it is constantly high.
- CONVERT:
  - `p_dRamp` is 0 on the first cycle and increments by 1 each cycle.
  - Reaches 2^RAMP_BITS−1 on the last cycle; lasts 2^RAMP_BITS cycles.
  - No wrap inside the state.
  - `p_dRamp`=0 in all other states.
- READOUT:
  - Rows r=0..ROWS−1 in order, each for READ_CYCLES cycles.
  - `p_row_select`=1<<r and `row_index`=r.
  - `row_valid`=1 only on the last cycle of each row.
  - `p_row_select`=0 outside READOUT.
- DONE:
  - One cycle with `frame_done`=1 and `busy`=1.
  - Samples `continuous` on this cycle.
  - If `continuous` is high, the next state is ERASE and `expose_time` is re-latched.
- `start` is ignored while busy.
- `expose_time` changes mid-frame have no effect on the current frame.
- Deasserting `continuous` mid-frame lets the current frame finish, then the block returns to IDLE.
- Simultaneous `start` and `continuous` in IDLE start one frame. Repetition follows `continuous` at DONE.

## Timing
- Reset (`reset`=0 at an edge):
  - Next state IDLE; all counters cleared.
  - Every output 0 after that edge, including mid-frame.
  - No partial-frame completion; no `frame_done` pulse.
- Start latency: `start` high at edge k in IDLE → `p_erase`=1 and `busy`=1 from edge k.
- Frame length, ERASE start to DONE inclusive: ERASE_CYCLES + E + 2^RAMP_BITS + ROWS·READ_CYCLES + 1 cycles.
  - Defaults with E=10: 5+10+256+8+1 = 280.
- Continuous mode: the next frame's `p_erase` rises on the edge after `frame_done`, with zero IDLE gap.
- Control lines `p_erase`, `p_expose` and `p_row_select` are never high simultaneously.

## Test plan
- Default single-shot:
  - Stimulus: reset low 2 cycles, `expose_time`=10, 1-cycle `start`.
  - Expected: `p_erase` high 5 cycles, `p_expose` high 10 with 5 `p_expose_clk` pulses, `p_dRamp` 0..255, each row selected 2 cycles with `row_valid` on its 2nd cycle, `frame_done` at cycle 280, then IDLE.
- Zero exposure:
  - Stimulus: `expose_time`=0.
  - Expected: `p_expose` high exactly 1 cycle; frame length 271.
- Continuous:
  - Stimulus: `continuous`=1 for 3 frames, with `expose_time` changed to 3 during frame 1.
  - Expected: frame 1 uses E=10 and frame 2 uses E=3; `p_erase` follows `frame_done` with no gap.
  - Expected: dropping `continuous` during frame 3 ends in IDLE after its `frame_done`.
- Reset mid-CONVERT:
  - Stimulus: assert reset while `p_dRamp`=100.
  - Expected: all outputs 0 on the next edge, no `frame_done`, and a fresh `start` gives a full 280-cycle frame.
- Busy start:
  - Stimulus: pulse `start` during EXPOSE.
  - Expected: ignored; exactly one `frame_done`.
- Parameter sweep:
  - Stimulus: ROWS=8, RAMP_BITS=4, READ_CYCLES=1, EXPOSE_CLK_DIV=1.
  - Expected: 8 one-hot rows each with `row_valid`, ramp 0..15, `p_expose_clk` constantly high during EXPOSE, frame length matches the formula.
